// File: rtl/decode.sv
// RV32I decode stage: latches one instruction, reads its two source registers,
// and presents registered decode fields with a one-cycle done pulse two cycles later.
module decode (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [31:0] command,
  input  logic [31:0] pc,
  output logic [4:0]  rs1addr,
  output logic [4:0]  rs2addr,
  input  logic [31:0] rs1data,
  input  logic [31:0] rs2data,
  output logic        done,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [31:0] pc_out,
  output logic        regwrite,
  output logic        illegal
);

  typedef enum logic [1:0] {StIdle, StRead, StOut} state_e;

  state_e      state_q, state_d;
  logic [31:0] cmd_q, cmd_d, pc_q, pc_d;
  logic [4:0]  rs1addr_q, rs1addr_d, rs2addr_q, rs2addr_d, rd_q, rd_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        funct7b5_q, funct7b5_d, done_q, done_d;
  logic [31:0] imm_q, imm_d, src1_q, src1_d, src2_q, src2_d, pc_out_q, pc_out_d;
  logic        regwrite_q, regwrite_d, illegal_q, illegal_d;

  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic [2:0]  dec_f3;

  // Field decode works on the latched word so outputs never see command directly.
  always_comb begin
    dec_imm     = 32'h0;
    dec_illegal = 1'b0;
    dec_f3      = cmd_q[14:12];
    unique case (cmd_q[6:0])
      7'h03: begin
        dec_imm     = {{20{cmd_q[31]}}, cmd_q[31:20]};
        dec_illegal = (dec_f3 == 3'd3) || (dec_f3 == 3'd6) || (dec_f3 == 3'd7);
      end
      7'h13: dec_imm = {{20{cmd_q[31]}}, cmd_q[31:20]};
      7'h67: begin
        dec_imm     = {{20{cmd_q[31]}}, cmd_q[31:20]};
        dec_illegal = (dec_f3 != 3'd0);
      end
      7'h23: begin
        dec_imm     = {{20{cmd_q[31]}}, cmd_q[31:25], cmd_q[11:7]};
        dec_illegal = (dec_f3 > 3'd2);
      end
      7'h63: begin
        dec_imm     = {{19{cmd_q[31]}}, cmd_q[31], cmd_q[7], cmd_q[30:25], cmd_q[11:8], 1'b0};
        dec_illegal = (dec_f3 == 3'd2) || (dec_f3 == 3'd3);
      end
      7'h37, 7'h17: dec_imm = {cmd_q[31:12], 12'h0};
      7'h6f: dec_imm = {{11{cmd_q[31]}}, cmd_q[31], cmd_q[19:12], cmd_q[20], cmd_q[30:21], 1'b0};
      7'h33: dec_imm = 32'h0;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    pc_d       = pc_q;
    rs1addr_d  = rs1addr_q;
    rs2addr_d  = rs2addr_q;
    rd_d       = rd_q;
    opcode_d   = opcode_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    imm_d      = imm_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    pc_out_d   = pc_out_q;
    regwrite_d = regwrite_q;
    illegal_d  = illegal_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          cmd_d     = command;
          pc_d      = pc;
          rs1addr_d = command[19:15];
          rs2addr_d = command[24:20];
          state_d   = StRead;
        end
      end
      StRead: begin
        state_d    = StOut;
        done_d     = 1'b1;
        opcode_d   = cmd_q[6:0];
        funct3_d   = cmd_q[14:12];
        funct7b5_d = cmd_q[30];
        rd_d       = cmd_q[11:7];
        imm_d      = dec_imm;
        src1_d     = (cmd_q[19:15] == 5'd0) ? 32'h0 : rs1data;
        src2_d     = (cmd_q[24:20] == 5'd0) ? 32'h0 : rs2data;
        pc_out_d   = pc_q;
        illegal_d  = dec_illegal;
        regwrite_d = !dec_illegal && (cmd_q[6:0] != 7'h23) && (cmd_q[6:0] != 7'h63) &&
                     (cmd_q[11:7] != 5'd0);
      end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cmd_q      <= 32'h0;
      pc_q       <= 32'h0;
      rs1addr_q  <= 5'd0;
      rs2addr_q  <= 5'd0;
      rd_q       <= 5'd0;
      opcode_q   <= 7'd0;
      funct3_q   <= 3'd0;
      funct7b5_q <= 1'b0;
      imm_q      <= 32'h0;
      src1_q     <= 32'h0;
      src2_q     <= 32'h0;
      pc_out_q   <= 32'h0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      pc_q       <= pc_d;
      rs1addr_q  <= rs1addr_d;
      rs2addr_q  <= rs2addr_d;
      rd_q       <= rd_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      imm_q      <= imm_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      pc_out_q   <= pc_out_d;
      regwrite_q <= regwrite_d;
      illegal_q  <= illegal_d;
      done_q     <= done_d;
    end
  end

  assign rs1addr  = rs1addr_q;
  assign rs2addr  = rs2addr_q;
  assign done     = done_q;
  assign opcode   = opcode_q;
  assign funct3   = funct3_q;
  assign funct7b5 = funct7b5_q;
  assign rd       = rd_q;
  assign imm      = imm_q;
  assign src1     = src1_q;
  assign src2     = src2_q;
  assign pc_out   = pc_out_q;
  assign regwrite = regwrite_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: vector table of RV32I words plus busy, x0 and reset-abort sequences.
module tb_decode;

  logic        clk = 1'b0;
  logic        rstn, enable;
  logic [31:0] command, pc, rs1data, rs2data;
  logic [4:0]  rs1addr, rs2addr, rd;
  logic        done, funct7b5, regwrite, illegal;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm, src1, src2, pc_out;

  int n_tests = 0;
  int n_fail  = 0;

  decode dut (
    .clk(clk), .rstn(rstn), .enable(enable), .command(command), .pc(pc),
    .rs1addr(rs1addr), .rs2addr(rs2addr), .rs1data(rs1data), .rs2data(rs2data),
    .done(done), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .rd(rd),
    .imm(imm), .src1(src1), .src2(src2), .pc_out(pc_out), .regwrite(regwrite),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd, pc, d1, d2;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd, rs1a, rs2a;
    logic [31:0] imm, s1, s2;
    logic        rw, ill;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, " opcode"}, 32'(opcode), 32'(v.op));
    chk({tag, " funct3"}, 32'(funct3), 32'(v.f3));
    chk({tag, " funct7b5"}, 32'(funct7b5), 32'(v.f7b5));
    chk({tag, " rd"}, 32'(rd), 32'(v.rd));
    chk({tag, " rs1addr"}, 32'(rs1addr), 32'(v.rs1a));
    chk({tag, " rs2addr"}, 32'(rs2addr), 32'(v.rs2a));
    chk({tag, " imm"}, imm, v.imm);
    chk({tag, " src1"}, src1, v.s1);
    chk({tag, " src2"}, src2, v.s2);
    chk({tag, " pc_out"}, pc_out, v.pc);
    chk({tag, " regwrite"}, 32'(regwrite), 32'(v.rw));
    chk({tag, " illegal"}, 32'(illegal), 32'(v.ill));
  endtask

  task automatic chk_all_zero(input string tag);
    vec_t z;
    z = '{cmd: 0, pc: 0, d1: 0, d2: 0, op: 0, f3: 0, f7b5: 0, rd: 0, rs1a: 0, rs2a: 0,
          imm: 0, s1: 0, s2: 0, rw: 0, ill: 0};
    chk({tag, " done"}, 32'(done), 32'h0);
    chk_outputs(tag, z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              cmd           pc       d1      d2      op     f3 f7 rd  rs1 rs2 imm       s1      s2      rw ill
    vecs[0] = '{32'h00510093, 32'h100, 32'h10, 32'h10, 7'h13, 0, 0, 1,  2,  5,  32'h5,
                32'h10, 32'h10, 1, 0};
    vecs[1] = '{32'hFE208EE3, 32'h200, 32'h11, 32'h22, 7'h63, 0, 1, 29, 1,  2,  32'hFFFFFFFC,
                32'h11, 32'h22, 0, 0};
    vecs[2] = '{32'h123452B7, 32'h300, 32'hA,  32'hB,  7'h37, 5, 0, 5,  8,  3,  32'h12345000,
                32'hA,  32'hB,  1, 0};
    vecs[3] = '{32'h00000000, 32'h400, 32'h55, 32'h55, 7'h00, 0, 0, 0,  0,  0,  32'h0,
                32'h0,  32'h0,  0, 1};
    vecs[4] = '{32'h0020A423, 32'h404, 32'h1000, 32'h77, 7'h23, 2, 0, 8, 1,  2,  32'h8,
                32'h1000, 32'h77, 0, 0};
    vecs[5] = '{32'h00003083, 32'h408, 32'h9,  32'h9,  7'h03, 3, 0, 1,  0,  0,  32'h0,
                32'h0,  32'h0,  0, 1};
    vecs[6] = '{32'hFF9FF0EF, 32'h40C, 32'h1,  32'h2,  7'h6F, 7, 1, 1,  31, 25, 32'hFFFFFFF8,
                32'h1,  32'h2,  1, 0};
    vecs[7] = '{32'h405201B3, 32'h410, 32'h44, 32'h55, 7'h33, 0, 1, 3,  4,  5,  32'h0,
                32'h44, 32'h55, 1, 0};
    vecs[8] = '{32'h00009067, 32'h414, 32'h66, 32'h99, 7'h67, 1, 0, 0,  1,  0,  32'h0,
                32'h66, 32'h0,  0, 1};

    rstn = 1'b0; enable = 1'b0; command = 32'h0; pc = 32'h0; rs1data = 32'h0; rs2data = 32'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Table: enable sampled at edge e0, done visible in the cycle after e1, gone after e2.
    foreach (vecs[i]) begin
      enable = 1'b1; command = vecs[i].cmd; pc = vecs[i].pc;
      rs1data = vecs[i].d1; rs2data = vecs[i].d2;
      @(negedge clk);
      enable = 1'b0; command = 32'hFFFF_FFFF; pc = 32'hFFFF_FFFF;
      chk($sformatf("v%0d done@T+1", i), 32'(done), 32'h0);
      chk($sformatf("v%0d rs1addr@T+1", i), 32'(rs1addr), 32'(vecs[i].rs1a));
      chk($sformatf("v%0d rs2addr@T+1", i), 32'(rs2addr), 32'(vecs[i].rs2a));
      @(negedge clk);
      chk($sformatf("v%0d done@T+2", i), 32'(done), 32'h1);
      chk_outputs($sformatf("v%0d", i), vecs[i]);
      rs1data = 32'h0BAD_0BAD; rs2data = 32'h0BAD_0BAD;
      @(negedge clk);
      chk($sformatf("v%0d done@T+3", i), 32'(done), 32'h0);
      chk($sformatf("v%0d imm hold", i), imm, vecs[i].imm);
      chk($sformatf("v%0d src1 hold", i), src1, vecs[i].s1);
    end

    // Busy: re-pulse at T+1 is ignored; rs1=x0 forces src1 to zero.
    enable = 1'b1; command = 32'h00700093; pc = 32'h500;
    rs1data = 32'hDEADBEEF; rs2data = 32'h3;
    @(negedge clk);
    command = 32'h123452B7; pc = 32'h600;
    chk("busy done@T+1", 32'(done), 32'h0);
    @(negedge clk);
    enable = 1'b0;
    chk("busy done@T+2", 32'(done), 32'h1);
    chk("busy opcode", 32'(opcode), 32'h13);
    chk("busy imm", imm, 32'h7);
    chk("busy rd", 32'(rd), 32'h1);
    chk("busy src1 x0", src1, 32'h0);
    chk("busy src2", src2, 32'h3);
    chk("busy pc_out", pc_out, 32'h500);
    @(negedge clk);
    chk("busy done@T+3", 32'(done), 32'h0);
    @(negedge clk);
    chk("busy done@T+4", 32'(done), 32'h0);
    @(negedge clk);
    chk("busy done@T+5", 32'(done), 32'h0);

    // Reset abort during READ, then enable in the first cycle after release.
    enable = 1'b1; command = 32'h00510093; pc = 32'h700; rs1data = 32'h10; rs2data = 32'h10;
    @(negedge clk);
    enable = 1'b0; rstn = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    rstn = 1'b1; enable = 1'b1; command = 32'h123452B7; pc = 32'h800;
    rs1data = 32'hA; rs2data = 32'hB;
    @(negedge clk);
    enable = 1'b0;
    chk("abort no done", 32'(done), 32'h0);
    @(negedge clk);
    chk("post-reset done", 32'(done), 32'h1);
    chk("post-reset imm", imm, 32'h12345000);
    chk("post-reset rd", 32'(rd), 32'h5);
    chk("post-reset pc_out", pc_out, 32'h800);
    @(negedge clk);
    chk("post-reset done off", 32'(done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
